// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants for the addsub_seq sequencing front end.
//   - opcode encodings presented on in_op
//   - bit positions inside the 4-bit {V,N,Z,C} flag vector
//   - FSM state encoding
package addsub_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

    localparam int NUM_FLAGS = 4;
    localparam int FLG_C     = 0;
    localparam int FLG_Z     = 1;
    localparam int FLG_N     = 2;
    localparam int FLG_V     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/AddSub8bit.sv
// AddSub8bit: combinational 8-bit adder/subtractor core.
//   inp1, inp2 : operands
//   carryin    : 0 = add (inp1 + inp2), 1 = subtract (inp1 + ~inp2 + 1)
//   sum        : 8-bit result, modulo 256
//   carryout   : carry out of bit 7 (for subtract, 1 means no borrow)
module AddSub8bit (
    input  logic [7:0] inp1,
    input  logic [7:0] inp2,
    input  logic       carryin,
    output logic [7:0] sum,
    output logic       carryout
);

    logic [7:0] inp2_eff;

    // carryin doubles as the subtract select and the +1 of two's complement
    assign inp2_eff          = inp2 ^ {8{carryin}};
    assign {carryout, sum}   = {1'b0, inp1} + {1'b0, inp2_eff} + {8'd0, carryin};

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: valid/ready sequencer around the AddSub8bit core.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (in_ready only in IDLE)
//   in_op, in_a, in_b   : opcode and operands (in_a ignored for ACC_* ops)
//   acc_clr             : synchronous accumulator clear, any state
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   out_sum, out_flags  : registered result and {V,N,Z,C}
//   acc                 : accumulator, written by every op
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic [NUM_FLAGS-1:0] out_flags,
    output logic [WIDTH-1:0]     acc
);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic                  mode_q, mode_d;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic [NUM_FLAGS-1:0]  flags_q, flags_d;
    logic [WIDTH-1:0]      acc_q, acc_d;

    logic [WIDTH-1:0]      core_sum;
    logic                  core_cout;
    logic [WIDTH-1:0]      b_eff;
    logic                  is_acc_op;

    AddSub8bit u_addsub (
        .inp1     (a_q),
        .inp2     (b_q),
        .carryin  (mode_q),
        .sum      (core_sum),
        .carryout (core_cout)
    );

    // operand B as the core actually adds it, needed for signed overflow
    assign b_eff     = mode_q ? ~b_q : b_q;
    assign is_acc_op = (in_op == OP_ACC_ADD) || (in_op == OP_ACC_SUB);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        sum_d   = sum_q;
        flags_d = flags_q;
        acc_d   = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // acc_q is the pre-clear value even if acc_clr is high now
                    a_d     = is_acc_op ? acc_q : in_a;
                    b_d     = in_b;
                    mode_d  = in_op[0];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                sum_d          = core_sum;
                flags_d[FLG_C] = core_cout;
                flags_d[FLG_Z] = (core_sum == '0);
                flags_d[FLG_N] = core_sum[WIDTH-1];
                flags_d[FLG_V] = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                                 (core_sum[WIDTH-1] != a_q[WIDTH-1]);
                acc_d          = core_sum;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // clear beats the EXEC write-back
        if (acc_clr) acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            sum_q   <= '0;
            flags_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign out_flags = flags_q;
    assign acc       = acc_q;

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Sequencing front end for the 8-bit adder/subtractor datapath. Accepts operation requests over a valid/ready handshake, registers the operands, and drives the combinational `AddSub8bit` core (`inp1`, `inp2`, `carryin` as the subtract select). It captures `sum` and `carryout`, derives status flags, and maintains an 8-bit accumulator for chained operations. Results leave through a valid/ready output port to downstream consumers.

## Interface
- `WIDTH`, 8, operand/result width; fixed at 8 to match `AddSub8bit`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request.
- `in_op` in 2: opcode. 00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB.
- `in_a` in 8: operand A; ignored for ACC_* ops.
- `in_b` in 8: operand B.
- `acc_clr` in 1: synchronous accumulator clear.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer accepts result.
- `out_sum` out 8: result.
- `out_flags` out 4: {V, N, Z, C}.
- `acc` out 8: current accumulator value.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, latch the operand registers and go to EXEC. The A register gets `in_a` for ADD/SUB and `acc` for ACC_*. The B register gets `in_b`. The mode register gets `in_op[0]`.
  - EXEC: registered operands drive the core, with `carryin` = mode. At the end of the cycle, capture `sum` into `out_sum`, compute the flags, write `sum` into `acc`, and go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE. Otherwise hold all outputs stable.
- `in_ready` is 1 only in IDLE. Requests presented in other states are not consumed.
- Arithmetic: SUB computes A + ~B + 1, modulo 256.
- Flags:
  - C = raw `carryout`. For SUB, C=1 means no borrow.
  - Z = (sum==0).
  - N = sum[7].
  - V = signed overflow: (A[7]==B'[7]) && (sum[7]!=A[7]), where B' = B for ADD and ~B for SUB.
- `acc` is updated by every op, including plain ADD/SUB.
- `acc_clr` takes effect in any state. If it coincides with the EXEC capture, the clear wins: `acc`=0, while `out_sum` still takes `sum`. If it coincides with an ACC_* accept in IDLE, the operand A register latches the pre-clear `acc`.

## Timing
- Reset values:
  - state = IDLE, `in_ready`=1 after reset deasserts.
  - `out_valid`, `out_sum`, `out_flags`, `acc`, and the operand and mode registers = 0.
- Latency: accept at edge N, capture at edge N+1, `out_valid`=1 during the cycle after edge N+1.
- Maximum throughput is one op per 3 cycles with `out_ready` tied high.
- Backpressure: while `out_ready`=0 in DONE, `out_sum`, `out_flags`, and `acc` stay frozen (except for `acc_clr`), and `in_ready` stays 0.
- Reset mid-operation from EXEC or DONE returns to IDLE on the next edge. The in-flight result is discarded and no `out_valid` pulse is emitted.
- The core is purely combinational. Its path from operand registers to output registers must close within one cycle.

## Structure
- Package `addsub_pkg` holds:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_ACC_ADD`, `OP_ACC_SUB`;
  - flag bit indices `FLG_C`=0, `FLG_Z`=1, `FLG_N`=2, `FLG_V`=3;
  - the FSM state encoding.
- One sub-module: the existing `AddSub8bit`, instantiated unmodified as `u_addsub`. Flag logic and the FSM stay in `addsub_seq`.

## Test plan
- ADD: A=0x01, B=0x12. Expect `out_sum`=0x13 and flags V0 N0 Z0 C0, with `out_valid` two edges after accept.
- SUB: A=0x49, B=0x55. Expect `out_sum`=0xF4 (−12) and flags V0 N1 Z0 C0. Then A=0x80, B=0x01: expect 0x7F, V1 N0 Z0 C1.
- Overflow and zero:
  - ADD 0x7F+0x01 → 0x80, V1 N1 C0.
  - ADD 0xFF+0x01 → 0x00, Z1 C1 V0.
- Accumulate:
  - `acc_clr`, then ACC_ADD B=0x07 → `acc`=0x07.
  - ACC_ADD B=0x05 → 0x0C.
  - ACC_SUB B=0x0C → 0x00 with Z1 C1.
  - `acc_clr` coincident with the EXEC capture → `acc`=0 while `out_sum` shows the computed value.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. `out_sum`, `out_flags`, and `out_valid` stay stable and `in_ready`=0. A concurrent `in_valid` is not consumed until after the handshake completes.
- Reset in EXEC: assert `rst` for one cycle. Next cycle state is IDLE, `out_valid`=0, `acc`=0, `in_ready`=1, and no spurious result appears.
